div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle request to begin a division.
REQ-005 Port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 Port: dividend  input  WIDTH  numerator, sampled on the accepted start.
REQ-007 Port: divisor  input  WIDTH  denominator, sampled on the accepted start.
REQ-008 Port: busy  output  1  high while a division is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 Port: quotient  output  WIDTH  LO result; feeds the writeback data mux.
REQ-011 Port: remainder  output  WIDTH  HI result; feeds the writeback data mux.
REQ-012 The design SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-014 Transitions:
- IDLE to RUN on start.
- RUN to FINISH when the iteration count reaches WIDTH.
- FINISH to IDLE unconditionally.
REQ-015 On the accepted start, the block SHALL latch is_signed, the operand signs, and the operand magnitudes; it SHALL take the absolute value only when is_signed=1.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle, using a 6-bit counter and a WIDTH+1-bit partial remainder.
REQ-017 busy SHALL be 1 in RUN and FINISH, and 0 in IDLE.
REQ-018 Latency:
- The start edge is cycle 0.
- done SHALL be 1 for exactly cycle WIDTH+1 (cycle 33).
- quotient and remainder SHALL update in that same cycle.
REQ-019 quotient and remainder SHALL hold their value until the next done; they SHALL never show intermediate values.
REQ-020 A start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 A start in the same cycle as FINISH to IDLE SHALL be ignored; a new start is accepted only in IDLE.
REQ-022 Signed sign rules: the quotient sign SHALL be sign(dividend) XOR sign(divisor), and the remainder SHALL take the sign of the dividend.
REQ-023 Signed overflow: 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-024 Divide by zero (base behaviour): the block SHALL run the full 32 cycles, giving an unsigned magnitude quotient of 0xFFFFFFFF and a remainder equal to the dividend magnitude, then apply the REQ-022 sign fixes.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, quotient=0, remainder=0, counter=0, and all latched operands at 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; after release the block SHALL accept a new start in the first cycle.

Configuration
REQ-027 The macro DIV_ZERO_FAST_EN SHALL control fast divide-by-zero handling.
REQ-028 With DIV_ZERO_FAST_EN defined:
- Output port div_zero (1 bit) SHALL exist.
- A start with divisor=0 SHALL go IDLE to FINISH directly, skipping RUN.
- done SHALL pulse in cycle 2 with quotient=0xFFFFFFFF and remainder=dividend (raw, with no sign fixes).
- div_zero SHALL be 1 alongside done and hold until the next accepted start.
- div_zero SHALL reset to 0.
REQ-029 With DIV_ZERO_FAST_EN undefined, the div_zero port SHALL be absent and REQ-024 behaviour SHALL apply.

Structure
REQ-030 Package div_pkg SHALL hold the following, and the RTL SHALL import them from div_pkg:
- the FSM state enum (IDLE, RUN, FINISH);
- DIV_WIDTH=32;
- DIV_CNT_W=6.
REQ-031 A combinational sub-module, div_step, SHALL compute one restoring step: inputs are the partial remainder and the divisor; outputs are the next partial remainder and the quotient bit.
REQ-032 div_unit SHALL contain the FSM, the counter, the operand registers and the sign correction.

Verification
REQ-033 The bench SHALL cover at least the following directed scenarios:
- DIVU 100/7: done at cycle 33, quotient=14, remainder=2; busy high in cycles 1-33.
- DIV -7/2 (0xFFFFFFF9/2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7/-2 gives quotient=-3, remainder=1.
- DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0.
- Divisor 0, dividend 5, DIVU:
  - macro on: done at cycle 2, quotient=0xFFFFFFFF, remainder=5, div_zero=1;
  - macro off: done at cycle 33, same values.
- Second start at cycle 10 with different operands: ignored, and the first result is unchanged.
- rst_n low at cycle 15: busy=0, outputs 0; a start at the first post-reset cycle completes correctly 33 cycles later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
// Holds the FSM state encoding, the default operand width and the
// iteration counter width used by div_unit and div_step.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step (purely combinational).
// Ports:
//   part_rem         : shifted partial remainder entering this step (WIDTH+1)
//   divisor          : divisor magnitude (WIDTH)
//   part_rem_next_c  : partial remainder after the trial subtraction (WIDTH+1)
//   q_bit_c          : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   part_rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH+1:0] diff;

  // An extra guard bit turns the borrow into a plain sign test.
  always_comb begin
    diff            = {1'b0, part_rem} - {2'b00, divisor};
    q_bit_c         = ~diff[WIDTH+1];
    part_rem_next_c = q_bit_c ? diff[WIDTH:0] : part_rem;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV (signed) and DIVU (unsigned).
// A start accepted in IDLE latches the operands; RUN performs one
// shift-subtract step per cycle for WIDTH cycles; the sign-corrected
// quotient/remainder and a one-cycle done appear on entry to FINISH.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips RUN,
// returns all-ones / raw dividend and raises div_zero.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a division (accepted only in IDLE)
//   is_signed    : 1 = two's complement DIV, 0 = DIVU
//   dividend     : numerator, sampled on the accepted start
//   divisor      : denominator, sampled on the accepted start
//   busy         : high while an operation is in RUN or FINISH
//   done         : one-cycle result-valid pulse
//   quotient     : LO result, held until the next done
//   remainder    : HI result, held until the next done
//   div_zero     : (DIV_ZERO_FAST_EN only) fast divide-by-zero flag
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned      CNT_W    = DIV_CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             op_signed, op_signed_next;
  logic             sign_a, sign_a_next;
  logic             sign_b, sign_b_next;
  logic [WIDTH:0]   part_rem, part_rem_next;
  logic [WIDTH-1:0] quo_sh, quo_sh_next;
  logic [WIDTH-1:0] dvs, dvs_next;
  logic             busy_next, done_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
`ifdef DIV_ZERO_FAST_EN
  logic             div_zero_next;
`endif

  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   shifted_c, rem_step_c;
  logic             q_bit_c;
  logic [WIDTH-1:0] quo_step_c, rem_low_c;
  logic [WIDTH-1:0] q_fix_c, r_fix_c;
  logic             neg_q_c, neg_r_c;

  // Operand magnitudes; negation only for signed requests.
  always_comb begin
    mag_a_c = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b_c = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Shift the next dividend bit into the partial remainder. The top bit is
  // always zero after a restoring step (remainder < divisor), so drop it.
  assign shifted_c = (WIDTH + 1)'({part_rem, quo_sh[WIDTH-1]});

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem        (shifted_c),
    .divisor         (dvs),
    .part_rem_next_c (rem_step_c),
    .q_bit_c         (q_bit_c)
  );

  // Sign correction of the final-step magnitudes.
  always_comb begin
    quo_step_c = {quo_sh[WIDTH-2:0], q_bit_c};
    rem_low_c  = rem_step_c[WIDTH-1:0];
    neg_q_c    = op_signed && (sign_a ^ sign_b);
    neg_r_c    = op_signed && sign_a;
    q_fix_c    = neg_q_c ? -quo_step_c : quo_step_c;
    r_fix_c    = neg_r_c ? -rem_low_c  : rem_low_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    op_signed_next = op_signed;
    sign_a_next    = sign_a;
    sign_b_next    = sign_b;
    part_rem_next  = part_rem;
    quo_sh_next    = quo_sh;
    dvs_next       = dvs;
    done_next      = 1'b0;
    quotient_next  = quotient;
    remainder_next = remainder;
`ifdef DIV_ZERO_FAST_EN
    div_zero_next  = div_zero;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          op_signed_next = is_signed;
          sign_a_next    = dividend[WIDTH-1];
          sign_b_next    = divisor[WIDTH-1];
          quo_sh_next    = mag_a_c;
          dvs_next       = mag_b_c;
          part_rem_next  = '0;
          cnt_next       = '0;
`ifdef DIV_ZERO_FAST_EN
          div_zero_next  = 1'b0;
          state_next     = (divisor == '0) ? FINISH : RUN;
`else
          state_next     = RUN;
`endif
        end
      end
      RUN: begin
        part_rem_next = rem_step_c;
        quo_sh_next   = quo_step_c;
        cnt_next      = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          state_next     = FINISH;
          done_next      = 1'b1;
          quotient_next  = q_fix_c;
          remainder_next = r_fix_c;
        end
      end
      FINISH: begin
        state_next = IDLE;
`ifdef DIV_ZERO_FAST_EN
        // Only the fast path reaches FINISH with a zero divisor; the
        // latched magnitude re-negated is exactly the raw dividend.
        if (dvs == '0) begin
          done_next      = 1'b1;
          quotient_next  = '1;
          remainder_next = (op_signed && sign_a) ? -quo_sh : quo_sh;
          div_zero_next  = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      part_rem  <= '0;
      quo_sh    <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      op_signed <= op_signed_next;
      sign_a    <= sign_a_next;
      sign_b    <= sign_b_next;
      part_rem  <= part_rem_next;
      quo_sh    <= quo_sh_next;
      dvs       <= dvs_next;
      busy      <= busy_next;
      done      <= done_next;
      quotient  <= quotient_next;
      remainder <= remainder_next;
`ifdef DIV_ZERO_FAST_EN
      div_zero  <= div_zero_next;
`endif
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a
// negedge monitor pops and compares on every done.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
`ifdef DIV_ZERO_FAST_EN
  logic         div_zero;
`endif

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_FAST_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  lat;
    int unsigned  at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Reference: plain integer division on magnitudes plus the sign rules.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic sa, sb;
    longint unsigned ma, mb, qm, rm;
    sa = s & a[W-1];
    sb = s & b[W-1];
    ma = sa ? ((64'd1 << W) - 64'(a)) : 64'(a);
    mb = sb ? ((64'd1 << W) - 64'(b)) : 64'(b);
    if (mb == 0) begin
      qm = 64'h0000_0000_FFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    e.q   = W'((sa ^ sb) ? -qm : qm);
    e.r   = W'(sa ? -rm : rm);
    e.dz  = 1'b0;
    e.lat = 33;
    e.at  = 0;
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 2;
    end
`endif
    return e;
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at edge %0d, want no pending result", edges);
      end else begin
        e = exp_q.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("done_cycle", 64'(edges - e.at + 1), 64'(e.lat));
`ifdef DIV_ZERO_FAST_EN
        check("div_zero", 64'(div_zero), 64'(e.dz));
`endif
      end
    end
  end

  // Present one start pulse; returns the edge index that sampled it.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                       input int unsigned lat, output int unsigned e_start);
    exp_t e;
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    e_start   = edges;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.lat = lat;
    e.at  = edges;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int unsigned k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d results pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    int unsigned e0;
    m = model(s, a, b);
    issue(s, a, b, m.q, m.r, m.dz, m.lat, e0);
    wait_drain("random");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stim
    int unsigned e0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_quotient", 64'(quotient), 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    rst_n = 1'b1;

    // DIVU 100/7 with a cycle-by-cycle busy trace
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, e0);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("busy_cycle%0d", k), 64'(busy), 64'((k <= 33) ? 1 : 0));
      @(posedge clk);
      #1;
    end
    wait_drain("divu_100_7");

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, e0);
    wait_drain("div_m7_2");
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, e0);
    wait_drain("div_7_m2");
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, e0);
    wait_drain("div_overflow");
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, e0);
    wait_drain("divu_max_1");

`ifdef DIV_ZERO_FAST_EN
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, e0);
    wait_drain("div_zero_fast");
    repeat (3) @(negedge clk);
    check("div_zero_hold", 64'(div_zero), 64'(1));
`else
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 33, e0);
    wait_drain("div_zero_slow");
`endif

    // Starts while busy (cycle 10) and during FINISH (cycle 33) are ignored
    issue(1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 33, e0);
`ifdef DIV_ZERO_FAST_EN
    check("div_zero_clear", 64'(div_zero), 64'(0));
`endif
    while (edges < e0 + 9) @(negedge clk);
    is_signed = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (edges < e0 + 32) @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd77;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("busy_ignore");
    repeat (40) @(negedge clk);
    check("ignored_start_idle", 64'(busy), 64'(0));

    // Reset in cycle 15 aborts; the first post-reset cycle accepts a start
    issue(1'b0, 32'd12345, 32'd67, 32'd184, 32'd17, 1'b0, 33, e0);
    while (edges < e0 + 14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_quotient", 64'(quotient), 64'(0));
    check("abort_remainder", 64'(remainder), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, e0);
    wait_drain("post_reset");

    for (int i = 0; i < 24; i++) begin
      run_model(1'($urandom_range(0, 1)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
